// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider for the execute stage: radix-2 restoring,
// one quotient bit per cycle, signed/unsigned, HI=remainder / LO=quotient result.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, divisor;
  logic        aNeg, qNeg;

  logic [31:0] absA, absB;
  logic [33:0] trial;
  logic [31:0] remNext, quoNext, remFix, quoFix;

  assign absA = (signed_div && a[31]) ? (~a + 32'd1) : a;
  assign absB = (signed_div && b[31]) ? (~b + 32'd1) : b;

  // Partial remainder is always below the divisor, so a non-negative trial fits 32 bits.
  assign trial = {1'b0, rem, quo[31]} - {2'b00, divisor};

  always_comb begin
    remNext = {rem[30:0], quo[31]};
    quoNext = {quo[30:0], 1'b0};
    if (!trial[33]) begin
      remNext = trial[31:0];
      quoNext = {quo[30:0], 1'b1};
    end
  end

  assign quoFix = qNeg ? (~quoNext + 32'd1) : quoNext;
  assign remFix = aNeg ? (~remNext + 32'd1) : remNext;

  assign stall = start & ~ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      divisor <= 32'd0;
      aNeg    <= 1'b0;
      qNeg    <= 1'b0;
      ready   <= 1'b0;
      result  <= 64'h0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            cnt     <= 6'd0;
            rem     <= 32'd0;
            // Divide-by-zero returns the raw dividend as remainder, so keep it unmodified.
            quo     <= (b == 32'd0) ? a : absA;
            divisor <= absB;
            aNeg    <= signed_div & a[31];
            qNeg    <= signed_div & (a[31] ^ b[31]);
            state   <= (b == 32'd0) ? DIVZERO : ON;
          end
        end
        DIVZERO: begin
          if (annul) state <= IDLE;
          else begin
            result <= {quo, 32'hFFFF_FFFF};
            ready  <= 1'b1;
            state  <= END;
          end
        end
        ON: begin
          if (annul) state <= IDLE;
          else begin
            rem <= remNext;
            quo <= quoNext;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              result <= {remFix, quoFix};
              ready  <= 1'b1;
              cnt    <= 6'd0;
              state  <= END;
            end
          end
        end
        END:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-003 start  input  1  execute-stage divide request (divE); level, held by pipeline until ready.
REQ-004 signed_div  input  1  1 = signed divide (hassignE), 0 = unsigned; sampled with start in IDLE.
REQ-005 annul  input  1  cancel in-flight divide (flushE / exception).
REQ-006 a  input  32  dividend; sampled on accept.
REQ-007 b  input  32  divisor; sampled on accept.
REQ-008 stall  output  1  combinational: start & ~ready; freezes upstream stages.
REQ-009 ready  output  1  result valid, exactly one cycle per completed divide.
REQ-010 result  output  64  {hi = remainder[31:0], lo = quotient[31:0]}; feeds HI/LO write.

Function
REQ-011 States: IDLE, DIVZERO, ON, END; 6-bit iteration counter cnt.
REQ-012 IDLE & start & ~annul & b!=0 -> ON, cnt=0; latch |a|, |b| (magnitudes if signed_div, raw if not), sign of a, sign of a XOR sign of b.
REQ-013 IDLE & start & ~annul & b==0 -> DIVZERO.
REQ-014 ON: one radix-2 restoring step per cycle (shift 65-bit partial remainder/quotient left, trial-subtract divisor, set quotient bit on non-negative); cnt increments; at cnt==31 step completes -> END.
REQ-015 DIVZERO -> END with quotient=32'hFFFF_FFFF, remainder=a (raw value); no exception raised.
REQ-016 END -> IDLE unconditionally; ready=1 only in END.
REQ-017 Signed fixup at ON->END: quotient negated if operand signs differ; remainder negated if dividend negative; remainder sign always equals dividend sign.
REQ-018 0x8000_0000 / 0xFFFF_FFFF signed -> quotient 0x8000_0000, remainder 0 (no trap).
REQ-019 Latency: start seen in IDLE at cycle 0 -> ready in cycle 33 (32 ON cycles); div-by-zero -> ready in cycle 2.
REQ-020 stall high from cycle 0 through cycle 32, low in cycle 33; low whenever start low.
REQ-021 result register holds last value until next completion; unchanged by annul.
REQ-022 annul in any state other than IDLE -> IDLE next edge, ready stays 0, result unchanged; annul in IDLE blocks acceptance that cycle.
REQ-023 start deassert mid-operation without annul: operation continues, ready still pulses.
REQ-024 a, b, signed_div changes while not IDLE ignored.
REQ-025 start high in cycle after END: treated as new divide (back-to-back supported, no dead cycle beyond the IDLE acceptance cycle).

Reset
REQ-026 rst low: state=IDLE, cnt=0, ready=0, result=64'h0, internal operand registers 0; stall reflects start only.
REQ-027 rst low mid-operation aborts divide; after release block accepts new start in IDLE normally.

Verification
REQ-028 unsigned 100/7, start held -> stall cycles 0-32, ready in cycle 33, result={32'd2, 32'd14}.
REQ-029 signed -7/2 -> result={32'hFFFF_FFFF, 32'hFFFF_FFFD} (rem -1, quot -3); signed 7/-2 -> {32'd1, 32'hFFFF_FFFD}.
REQ-030 b=0, a=0x1234 -> ready in cycle 2, result={32'h0000_1234, 32'hFFFF_FFFF}.
REQ-031 signed 0x8000_0000 / 0xFFFF_FFFF -> result={32'h0, 32'h8000_0000}; unsigned same operands -> {32'h8000_0000, 32'h0}.
REQ-032 annul asserted at cycle 10 of a divide -> IDLE at cycle 11, no ready pulse, result keeps prior value; new start then completes normally.
REQ-033 rst pulled low at cycle 20 asynchronously (between edges) -> ready=0, result=0 immediately; two back-to-back divides after release both produce single ready pulses 34 cycles apart.
